// File: rtl/led_pulse_driver.sv
// Event-driven pulse stretcher for an LED or buzzer driver.
// Queues events that arrive mid-pulse and replays them after the low gap.
module led_pulse_driver #(
   parameter int unsigned ON_CYCLES  = 20000000,
   parameter int unsigned OFF_CYCLES = 10000000,
   parameter int unsigned QUEUE_MAX  = 15
) (
   input  logic       clock_100mhz,
   input  logic       reset_n,
   input  logic       event_pulse,
   input  logic       enable,
   input  logic       clear_ovf,
   output logic       drive_out,
   output logic       busy,
   output logic [3:0] pending,
   output logic       overflow
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2
   } state_t;

   localparam logic [24:0] ON_LOAD  = 25'(ON_CYCLES - 1);
   localparam logic [24:0] OFF_LOAD = 25'(OFF_CYCLES - 1);
   localparam logic [3:0]  QMAX     = 4'(QUEUE_MAX);

   state_t      state;
   state_t      nxt_state;
   logic [24:0] cnt;
   logic [24:0] nxt_cnt;
   logic [3:0]  nxt_pend;
   logic        nxt_ovf;
   logic        drop;
   logic        at_end;
   logic        queue_full;

   assign at_end     = (cnt == 25'd0);
   assign queue_full = (pending == QMAX);

   always_ff @(posedge clock_100mhz or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= 25'd0;
         drive_out <= 1'b0;
         busy      <= 1'b0;
         pending   <= 4'd0;
         overflow  <= 1'b0;
      end else begin
         state     <= nxt_state;
         cnt       <= nxt_cnt;
         drive_out <= (nxt_state == ON);
         busy      <= (nxt_state != IDLE);
         pending   <= nxt_pend;
         overflow  <= nxt_ovf;
      end
   end

   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      nxt_pend  = pending;
      drop      = 1'b0;

      if (!enable) begin
         nxt_state = IDLE;
         nxt_cnt   = 25'd0;
         nxt_pend  = 4'd0;
      end else begin
         unique case (state)
            IDLE: begin
               nxt_cnt = 25'd0;
               if (event_pulse) begin
                  nxt_state = ON;
                  nxt_cnt   = ON_LOAD;
               end
            end
            ON: begin
               if (at_end) begin
                  nxt_state = OFF;
                  nxt_cnt   = OFF_LOAD;
               end else begin
                  nxt_cnt = cnt - 25'd1;
               end
               if (event_pulse) begin
                  if (queue_full) drop = 1'b1;
                  else nxt_pend = pending + 4'd1;
               end
            end
            OFF: begin
               if (at_end) begin
                  // An event arriving now is consumed directly by the restart.
                  if (event_pulse) begin
                     nxt_state = ON;
                     nxt_cnt   = ON_LOAD;
                  end else if (pending != 4'd0) begin
                     nxt_state = ON;
                     nxt_cnt   = ON_LOAD;
                     nxt_pend  = pending - 4'd1;
                  end else begin
                     nxt_state = IDLE;
                     nxt_cnt   = 25'd0;
                  end
               end else begin
                  nxt_cnt = cnt - 25'd1;
                  if (event_pulse) begin
                     if (queue_full) drop = 1'b1;
                     else nxt_pend = pending + 4'd1;
                  end
               end
            end
            default: begin
               nxt_state = IDLE;
               nxt_cnt   = 25'd0;
               nxt_pend  = 4'd0;
            end
         endcase
      end
   end

   // A drop in the same cycle wins over a clear request.
   always_comb begin
      nxt_ovf = overflow;
      if (drop) nxt_ovf = 1'b1;
      else if (clear_ovf) nxt_ovf = 1'b0;
   end

endmodule
